// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: each request loads a per-channel down-counter whose
// nonzero state drives a stretched level, plus an accept toggle and an ignored-request flag.
module pulse_stretcher #(
    parameter int WIDTH     = 1,
    parameter int STRETCH   = 8,
    parameter int RETRIGGER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pulse_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] toggle_out,
    output logic [WIDTH-1:0] drop_pulse,
    output logic             busy
);

    localparam int              CW         = $clog2(STRETCH + 1);
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(STRETCH);
    localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
    localparam logic            RETRIG_EN  = (RETRIGGER != 32'sd0);

    logic [CW-1:0]    cnt_r [WIDTH];
    logic [CW-1:0]    cnt_s [WIDTH];
    logic [WIDTH-1:0] accept_s;
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] toggle_s;
    logic [WIDTH-1:0] drop_s;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] toggle_r;
    logic [WIDTH-1:0] drop_r;

    // Per-channel acceptance and next-state; level is derived from the next count so the
    // level register always mirrors cnt_r != 0 without a path from pulse_in to the output.
    always_comb begin
        accept_s = {WIDTH{1'b0}};
        level_s  = {WIDTH{1'b0}};
        toggle_s = toggle_r;
        drop_s   = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s[i]    = cnt_r[i];
            accept_s[i] = pulse_in[i] & ((cnt_r[i] == CNT_ZERO) | RETRIG_EN);
            if (accept_s[i]) begin
                cnt_s[i] = CNT_LOAD;
            end else if (cnt_r[i] != CNT_ZERO) begin
                cnt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_s[i] = CNT_ZERO;
            end
            level_s[i]  = (cnt_s[i] != CNT_ZERO);
            toggle_s[i] = toggle_r[i] ^ accept_s[i];
            drop_s[i]   = pulse_in[i] & ~accept_s[i];
        end
    end

    // State and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            level_r  <= {WIDTH{1'b0}};
            toggle_r <= {WIDTH{1'b0}};
            drop_r   <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
            level_r  <= level_s;
            toggle_r <= toggle_s;
            drop_r   <= drop_s;
        end
    end

    assign level_out  = level_r;
    assign toggle_out = toggle_r;
    assign drop_pulse = drop_r;
    assign busy       = |level_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: five parameterisations share stimulus and are checked against
// an end-of-stretch-time reference model plus directed constant expectations.
module tb_pulse_stretcher;

    localparam int S0 = 3, S1 = 3, S2 = 1, S3 = 8, S4 = 2;
    localparam int R0 = 1, R1 = 0, R2 = 0, R3 = 1, R4 = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pulse = 4'b0000;
    logic [3:0] lv [5];
    logic [3:0] tg [5];
    logic [3:0] dp [5];
    logic       bz [5];

    int s_tab [5] = '{S0, S1, S2, S3, S4};
    int r_tab [5] = '{R0, R1, R2, R3, R4};

    // Model: m_end is the last cycle in which the level is high (cycle t+1 follows edge t).
    int         m_end [5][4];
    logic [3:0] m_tg [5];
    logic [3:0] m_dp [5];
    logic [3:0] m_lv [5];
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(4), .STRETCH(S0), .RETRIGGER(R0)) u0 (.clk(clk), .rst_n(rst_n),
        .pulse_in(pulse), .level_out(lv[0]), .toggle_out(tg[0]), .drop_pulse(dp[0]), .busy(bz[0]));
    pulse_stretcher #(.WIDTH(4), .STRETCH(S1), .RETRIGGER(R1)) u1 (.clk(clk), .rst_n(rst_n),
        .pulse_in(pulse), .level_out(lv[1]), .toggle_out(tg[1]), .drop_pulse(dp[1]), .busy(bz[1]));
    pulse_stretcher #(.WIDTH(4), .STRETCH(S2), .RETRIGGER(R2)) u2 (.clk(clk), .rst_n(rst_n),
        .pulse_in(pulse), .level_out(lv[2]), .toggle_out(tg[2]), .drop_pulse(dp[2]), .busy(bz[2]));
    pulse_stretcher #(.WIDTH(4), .STRETCH(S3), .RETRIGGER(R3)) u3 (.clk(clk), .rst_n(rst_n),
        .pulse_in(pulse), .level_out(lv[3]), .toggle_out(tg[3]), .drop_pulse(dp[3]), .busy(bz[3]));
    pulse_stretcher #(.WIDTH(4), .STRETCH(S4), .RETRIGGER(R4)) u4 (.clk(clk), .rst_n(rst_n),
        .pulse_in(pulse), .level_out(lv[4]), .toggle_out(tg[4]), .drop_pulse(dp[4]), .busy(bz[4]));

    // Reference model evaluated at every rising edge from the sampled request and reset.
    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!rst_n) begin
                    m_end[k][ch] <= -1;
                    m_tg[k][ch]  <= 1'b0;
                    m_dp[k][ch]  <= 1'b0;
                    m_lv[k][ch]  <= 1'b0;
                end else if (pulse[ch] && (cyc > m_end[k][ch] || r_tab[k] != 0)) begin
                    m_end[k][ch] <= cyc + s_tab[k];
                    m_tg[k][ch]  <= ~m_tg[k][ch];
                    m_dp[k][ch]  <= 1'b0;
                    m_lv[k][ch]  <= 1'b1;
                end else begin
                    m_dp[k][ch]  <= pulse[ch];
                    m_lv[k][ch]  <= (cyc + 1 <= m_end[k][ch]);
                end
            end
        end
        cyc <= cyc + 1;
    end

    task automatic step(input logic [3:0] p);
        @(negedge clk);
        pulse = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (lv[k] !== 4'b0000 || tg[k] !== 4'b0000 || dp[k] !== 4'b0000 || bz[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_before_edge inst%0d level=%b toggle=%b drop=%b busy=%b expected all 0",
                         k, lv[k], tg[k], dp[k], bz[k]);
            end
        end
        pulse = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (lv[k] !== 4'b0000 || tg[k] !== 4'b0000 || dp[k] !== 4'b0000 || bz[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_held inst%0d level=%b toggle=%b drop=%b busy=%b expected all 0",
                         k, lv[k], tg[k], dp[k], bz[k]);
            end
        end
        @(negedge clk);
        pulse = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int hi0 = 0, hi1 = 0;
        for (int i = 0; i < 6; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000);
            hi0 += int'(lv[0][0]);
            hi1 += int'(lv[1][0]);
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== m_lv[k] || tg[k] !== m_tg[k] || dp[k] !== m_dp[k] || bz[k] !== (|m_lv[k])) begin
                    n_bad++;
                    $display("FAIL single inst%0d step%0d level=%b/%b toggle=%b/%b drop=%b/%b busy=%b (got/exp)",
                             k, i, lv[k], m_lv[k], tg[k], m_tg[k], dp[k], m_dp[k], bz[k]);
                end
            end
            n_cmp++;
            if (lv[0][3:1] !== 3'b000) begin
                n_bad++;
                $display("FAIL single_other_channels step%0d level=%b expected 000", i, lv[0][3:1]);
            end
        end
        n_cmp++;
        if (hi0 != 3 || hi1 != 3 || tg[0][0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_width high_cycles=%0d,%0d toggle=%b expected 3,3 and 1", hi0, hi1, tg[0][0]);
        end
    endtask

    task automatic test_retrigger();
        int hi0 = 0, hi1 = 0, dr0 = 0, dr1 = 0, gap = 0;
        logic [3:0] p_seq = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            step((i < 4 && p_seq[i]) ? 4'b0001 : 4'b0000);
            if (i < 5 && !lv[0][0]) gap++;
            hi0 += int'(lv[0][0]);
            hi1 += int'(lv[1][0]);
            dr0 += int'(dp[0][0]);
            dr1 += int'(dp[1][0]);
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== m_lv[k] || tg[k] !== m_tg[k] || dp[k] !== m_dp[k] || bz[k] !== (|m_lv[k])) begin
                    n_bad++;
                    $display("FAIL retrigger inst%0d step%0d level=%b/%b toggle=%b/%b drop=%b/%b busy=%b (got/exp)",
                             k, i, lv[k], m_lv[k], tg[k], m_tg[k], dp[k], m_dp[k], bz[k]);
                end
            end
        end
        n_cmp++;
        if (hi0 != 5 || gap != 0 || dr0 != 0 || hi1 != 3 || dr1 != 1) begin
            n_bad++;
            $display("FAIL retrigger_counts hi0=%0d gap=%0d dr0=%0d hi1=%0d dr1=%0d expected 5 0 0 3 1",
                     hi0, gap, dr0, hi1, dr1);
        end
    endtask

    task automatic test_back_to_back();
        int hi = 0, dr = 0, flips = 0, low = 0;
        logic prev;
        for (int i = 0; i < 6; i++) begin
            step((i < 4) ? 4'b0100 : 4'b0000);
            hi += int'(lv[2][2]);
            dr += int'(dp[2][2]);
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== m_lv[k] || tg[k] !== m_tg[k] || dp[k] !== m_dp[k] || bz[k] !== (|m_lv[k])) begin
                    n_bad++;
                    $display("FAIL back_to_back inst%0d step%0d level=%b/%b toggle=%b/%b drop=%b/%b busy=%b (got/exp)",
                             k, i, lv[k], m_lv[k], tg[k], m_tg[k], dp[k], m_dp[k], bz[k]);
                end
            end
        end
        n_cmp++;
        if (hi != 2 || dr != 2) begin
            n_bad++;
            $display("FAIL alternate_accept level_cycles=%0d drops=%0d expected 2 2", hi, dr);
        end
        for (int i = 0; i < 10; i++) begin
            prev = tg[0][1];
            step(4'b1111);
            if (tg[0][1] !== prev) flips++;
            if (lv[0][1] !== 1'b1) low++;
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== m_lv[k] || tg[k] !== m_tg[k] || dp[k] !== m_dp[k] || bz[k] !== (|m_lv[k])) begin
                    n_bad++;
                    $display("FAIL continuous inst%0d step%0d level=%b/%b toggle=%b/%b drop=%b/%b busy=%b (got/exp)",
                             k, i, lv[k], m_lv[k], tg[k], m_tg[k], dp[k], m_dp[k], bz[k]);
                end
            end
        end
        n_cmp++;
        if (flips != 10 || low != 0) begin
            n_bad++;
            $display("FAIL continuous_hold toggle_flips=%0d low_cycles=%0d expected 10 0", flips, low);
        end
    endtask

    task automatic test_independent();
        repeat (10) step(4'b0000);
        for (int i = 0; i < 5; i++) begin
            step((i == 0) ? 4'b1010 : (i == 1) ? 4'b0101 : 4'b0000);
            n_cmp++;
            if (bz[4] !== (i < 3) || lv[4] !== m_lv[4] || tg[4] !== m_tg[4] || dp[4] !== m_dp[4]) begin
                n_bad++;
                $display("FAIL independent step%0d busy=%b expected %b level=%b/%b toggle=%b/%b drop=%b/%b",
                         i, bz[4], (i < 3), lv[4], m_lv[4], tg[4], m_tg[4], dp[4], m_dp[4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(4'b0001);
        step(4'b0000);
        step(4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (lv[k] !== 4'b0000 || tg[k] !== 4'b0000 || dp[k] !== 4'b0000 || bz[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_async inst%0d level=%b toggle=%b drop=%b busy=%b expected all 0",
                         k, lv[k], tg[k], dp[k], bz[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000);
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== 4'b0000 || tg[k] !== 4'b0000 || dp[k] !== 4'b0000 || bz[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_quiet inst%0d step%0d level=%b toggle=%b drop=%b expected all 0",
                             k, i, lv[k], tg[k], dp[k]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse = 4'b0001;
        @(posedge clk);
        #1;
        n_cmp++;
        if (lv[3] !== 4'b0001 || tg[3] !== 4'b0001 || lv[1] !== 4'b0001) begin
            n_bad++;
            $display("FAIL first_edge_after_reset level=%b toggle=%b level1=%b expected 0001 0001 0001",
                     lv[3], tg[3], lv[1]);
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int ch = 0; ch < 4; ch++) begin
                p[ch] = ($urandom_range(0, 3) == 0);
            end
            step(p);
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (lv[k] !== m_lv[k] || tg[k] !== m_tg[k] || dp[k] !== m_dp[k] || bz[k] !== (|m_lv[k])) begin
                    n_bad++;
                    $display("FAIL random inst%0d iter%0d level=%b/%b toggle=%b/%b drop=%b/%b busy=%b (got/exp)",
                             k, i, lv[k], m_lv[k], tg[k], m_tg[k], dp[k], m_dp[k], bz[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_retrigger();
        test_back_to_back();
        test_independent();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter WIDTH, default 1: number of independent channels, legal range 1..32.
REQ-002 Parameter STRETCH, default 8: output high-time in clk cycles per accepted pulse, legal range 1..65535.
REQ-003 Parameter RETRIGGER, default 1: 1 = a pulse during an active stretch reloads it; 0 = such a pulse is ignored.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 pulse_in  input  WIDTH  per-channel request pulses, synchronous to clk, any length.
REQ-008 level_out  output  WIDTH  per-channel stretched level.
REQ-009 toggle_out  output  WIDTH  per-channel level that inverts once per accepted pulse.
REQ-010 drop_pulse  output  WIDTH  per-channel one-cycle flag marking an ignored pulse.
REQ-011 busy  output  1  OR-reduction of level_out.

Function
REQ-012 Each channel SHALL hold a down-counter cnt[i] of width $clog2(STRETCH+1) bits; channels share no state.
REQ-013 pulse_in[i] SHALL be sampled at every rising clk edge; each high sample is a request, so an N-cycle-high input gives N requests.
REQ-014 A request SHALL be accepted when cnt[i]==0, or when RETRIGGER==1 regardless of cnt[i].
REQ-015 On acceptance, cnt[i] SHALL load STRETCH; otherwise it SHALL decrement when nonzero and hold at 0 (no wrap below 0).
REQ-016 level_out[i] SHALL equal (cnt[i]!=0), driven from registered state only (no combinational path from pulse_in).
REQ-017 Latency: a request accepted at edge k from idle SHALL hold level_out[i] high for cycles k+1 through k+STRETCH inclusive, i.e. exactly STRETCH cycles.
REQ-018 With RETRIGGER==1, a request at edge j during an active stretch SHALL keep level_out[i] high continuously through cycle j+STRETCH, with no low gap.
REQ-019 With RETRIGGER==0, a request at an edge where cnt[i]!=0 (including cnt[i]==1) SHALL be ignored: the counter decrements normally and drop_pulse[i] is high for the following cycle only.
REQ-020 drop_pulse[i] SHALL be registered, 0 in every cycle not covered by REQ-019, and always 0 when RETRIGGER==1.
REQ-021 toggle_out[i] SHALL invert, registered, at every edge where a request is accepted (retriggers included) and hold otherwise.
REQ-022 Continuous pulse_in[i]=1 with RETRIGGER==1 SHALL hold level_out[i] high indefinitely and invert toggle_out[i] every cycle.
REQ-023 With STRETCH==1 and back-to-back requests under RETRIGGER==0, alternate requests SHALL be accepted and dropped.
REQ-024 busy SHALL be a combinational OR of the registered level_out bits.

Reset
REQ-025 While rst_n==0, all cnt[i]=0, level_out=0, toggle_out=0, drop_pulse=0 and busy=0, taking effect without a clock edge.
REQ-026 Reset asserted mid-stretch SHALL abort the stretch immediately; after release, no output changes until a new request is sampled.
REQ-027 Requests sampled at the first edge after rst_n rises SHALL be honoured normally.

Verification
REQ-028 WIDTH=4, STRETCH=3: 1-cycle pulse_in=4'b0001 at edge 10 -> level_out[0] high cycles 11-13, toggle_out[0] 0->1 at edge 10, other channels stay 0.
REQ-029 RETRIGGER=1, STRETCH=3: pulses at edges 10 and 12 -> level_out[0] high cycles 11-15 with no gap, toggle_out[0] returns to 0 after edge 12, drop_pulse=0.
REQ-030 RETRIGGER=0, STRETCH=3: pulses at edges 10 and 12 -> level_out[0] high cycles 11-13 only, drop_pulse[0] high in cycle 13 only, toggle_out[0] inverts once.
REQ-031 STRETCH=1, RETRIGGER=0, pulse_in[2] held high for edges 5-8 -> accepted at 5 and 7, dropped at 6 and 8, level_out[2] high in cycles 6 and 8.
REQ-032 STRETCH=8: request at edge 20, rst_n low during cycle 23 -> all outputs 0 asynchronously and stay 0 after release until the next pulse.
REQ-033 pulse_in=4'b1010 at edge 4, then 4'b0101 at edge 5, STRETCH=2 -> each channel stretches independently; busy high cycles 5-7.
